alu_uart_frame_ctrl: RTL
========================

ALU_UART_FRAME_CTRL -- requirements
Module: alu_uart_frame_ctrl

Interface
REQ-001 SHALL have parameter DBIT, default 8: UART data bits per byte.
REQ-002 SHALL have parameter NB_OP, default 6: opcode width; NB_OP <= DBIT.
REQ-003 SHALL have parameter NB_AB, default 16: operand/result width; an integer multiple of DBIT; NBYTES = NB_AB/DBIT.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 1000000: inter-byte timeout in clk cycles; 0 disables the timeout.
REQ-005 SHALL have ports (name, direction, width, meaning):
- clk, input, 1: single clock; all state changes on rising edge.
- reset, input, 1: synchronous, active-high.
- r_data, input, DBIT: RX FIFO head byte.
- rx_empty, input, 1: RX FIFO empty.
- rd_uart, output, 1: RX pop strobe.
- tx_full, input, 1: TX FIFO full.
- wr_uart, output, 1: TX push strobe.
- w_data, output, DBIT: TX byte.
- result, input, NB_AB: combinational ALU result.
- op_code, output, NB_OP: committed opcode to ALU.
- data_a, output, NB_AB: committed operand A.
- data_b, output, NB_AB: committed operand B.
- busy, output, 1: high whenever state != RX_OP.
- frame_done, output, 1: one-cycle pulse, last result byte pushed.
- frame_err, output, 1: one-cycle pulse, frame aborted on timeout.

Function
REQ-006 SHALL implement states RX_OP, RX_A, RX_B, EXEC, LATCH, TX with a byte index 0..NBYTES-1.
REQ-007 SHALL drive rd_uart = ~reset & ~rx_empty & (state in RX_OP/RX_A/RX_B), combinationally; the byte on r_data is consumed on the same clock edge, giving up to one byte per cycle.
REQ-008 In RX_OP, on a consumed byte, SHALL store r_data[NB_OP-1:0] into a shadow opcode, discard the upper bits, clear the index, and go to RX_A.
REQ-009 In RX_A and RX_B, each consumed byte SHALL fill shadow operand bits [DBIT*idx +: DBIT] (LSB byte first).
REQ-010 The byte with idx = NBYTES-1 SHALL clear idx and advance RX_A->RX_B or RX_B->EXEC.
REQ-011 op_code, data_a and data_b SHALL change only on the EXEC edge, where all three are loaded from the shadows simultaneously; EXEC lasts one cycle, then goes to LATCH.
REQ-012 LATCH SHALL capture result into result_reg, clear idx, and go to TX; total latency from the last operand-B byte edge to the first possible wr_uart is 2 cycles.
REQ-013 In TX, SHALL drive w_data = result_reg[DBIT*idx +: DBIT] and wr_uart = ~reset & ~tx_full & (state==TX), combinationally.
REQ-014 In TX, each push SHALL advance idx; while tx_full is high, the state and index SHALL hold with no push.
REQ-015 The push with idx = NBYTES-1 SHALL return the block to RX_OP and assert frame_done on the following cycle.
REQ-016 Outside TX, w_data SHALL be result_reg[DBIT-1:0] and wr_uart SHALL be 0.
REQ-017 The timeout counter SHALL clear on every consumed byte and on entry to RX_OP, and SHALL count only in RX_A and RX_B.
REQ-018 When the counter reaches TIMEOUT_CYC-1 with no byte in that cycle, the block SHALL go to RX_OP, pulse frame_err on the next cycle, leave op_code/data_a/data_b unchanged, and discard the shadows.
REQ-019 If a byte arrives in the same cycle as the timeout would fire, the byte SHALL win: it is consumed and no timeout occurs.
REQ-020 rx_empty SHALL be ignored in EXEC, LATCH and TX; bytes arriving then remain in the FIFO for the next frame.
REQ-021 The counter SHALL be wide enough for TIMEOUT_CYC with no wrap before expiry.

Reset
REQ-022 A sampled reset SHALL force the RX_OP state, idx=0, counter=0, and zero for op_code, data_a, data_b, shadows, result_reg, frame_done and frame_err.
REQ-023 While reset is high, rd_uart and wr_uart SHALL be 0.
REQ-024 Reset mid-frame SHALL discard all partial bytes; no frame_done or frame_err pulse SHALL follow.

Verification
REQ-025 NB_AB=16, bytes 0xE0,0x34,0x12,0x01,0x00 back-to-back, result=data_a+data_b -> op_code=0x20, data_a=0x1234, data_b=0x0001; pushes 0x35 then 0x12; frame_done pulses once.
REQ-026 Same frame with tx_full high for 5 cycles after LATCH -> no wr_uart during those cycles, then 0x35,0x12 pushed in order with no duplicates or losses.
REQ-027 TIMEOUT_CYC=10, bytes 0x01,0xAA then silence -> frame_err pulses 10 cycles after the 0xAA edge, outputs keep their prior values, and the next full frame is decoded correctly.
REQ-028 Reset asserted after 3 bytes -> all outputs return to 0; the next 5-byte frame is decoded from its first byte.
REQ-029 rx_empty toggling every other cycle plus 2 extra bytes queued during TX -> exactly one pop per available byte, operands correct, queued bytes start the next frame.
REQ-030 NB_AB=8 (NBYTES=1): frame 0x05,0x07,0x03 -> one result byte pushed, frame_done pulses once.

Source files
------------

// File: rtl/alu_uart_frame_ctrl_if.sv
// Bundle of UART FIFO handshakes, ALU operand/result bus and frame status
// between the frame controller (master) and its environment (slave).
interface alu_uart_frame_ctrl_if #(
  parameter int DBIT  = 8,
  parameter int NB_OP = 6,
  parameter int NB_AB = 16
);
  logic [DBIT-1:0]  r_data;
  logic             rx_empty;
  logic             rd_uart;
  logic             tx_full;
  logic             wr_uart;
  logic [DBIT-1:0]  w_data;
  logic [NB_AB-1:0] result;
  logic [NB_OP-1:0] op_code;
  logic [NB_AB-1:0] data_a;
  logic [NB_AB-1:0] data_b;
  logic             busy;
  logic             frame_done;
  logic             frame_err;

  modport master (
    input  r_data, rx_empty, tx_full, result,
    output rd_uart, wr_uart, w_data, op_code, data_a, data_b,
           busy, frame_done, frame_err
  );

  modport slave (
    output r_data, rx_empty, tx_full, result,
    input  rd_uart, wr_uart, w_data, op_code, data_a, data_b,
           busy, frame_done, frame_err
  );
endinterface

// File: rtl/alu_uart_frame_ctrl.sv
// UART frame controller for an ALU: receives opcode + operand A + operand B
// (LSB byte first), commits them to the ALU together, latches the result and
// sends it back LSB byte first. Partial frames are dropped on inter-byte timeout.
module alu_uart_frame_ctrl #(
  parameter int DBIT        = 8,
  parameter int NB_OP       = 6,
  parameter int NB_AB       = 16,
  parameter int TIMEOUT_CYC = 1000000
) (
  input logic                  clk,
  input logic                  reset,
  alu_uart_frame_ctrl_if.master bus
);

  localparam int NBYTES = NB_AB / DBIT;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int CNT_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  localparam logic [2:0] ST_RX_OP = 3'd0;
  localparam logic [2:0] ST_RX_A  = 3'd1;
  localparam logic [2:0] ST_RX_B  = 3'd2;
  localparam logic [2:0] ST_EXEC  = 3'd3;
  localparam logic [2:0] ST_LATCH = 3'd4;
  localparam logic [2:0] ST_TX    = 3'd5;

  logic [2:0]       r_state;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [NB_OP-1:0] r_op_sh;
  logic [NB_AB-1:0] r_a_sh;
  logic [NB_AB-1:0] r_b_sh;
  logic [NB_OP-1:0] r_op;
  logic [NB_AB-1:0] r_a;
  logic [NB_AB-1:0] r_b;
  logic [NB_AB-1:0] r_res;
  logic             r_done;
  logic             r_err;

  logic w_rx_state;
  logic w_cnt_state;
  logic w_rd;
  logic w_wr;
  logic w_last;
  logic w_tmo;

  assign w_rx_state  = (r_state == ST_RX_OP) || (r_state == ST_RX_A) || (r_state == ST_RX_B);
  assign w_cnt_state = (r_state == ST_RX_A) || (r_state == ST_RX_B);
  assign w_rd        = ~reset & ~bus.rx_empty & w_rx_state;
  assign w_wr        = ~reset & ~bus.tx_full & (r_state == ST_TX);
  assign w_last      = (r_idx == IDX_LAST);
  // A byte in the expiry cycle wins because w_rd masks the timeout.
  assign w_tmo       = (TIMEOUT_CYC != 0) && w_cnt_state && !w_rd && (r_cnt == CNT_LAST);

  assign bus.rd_uart    = w_rd;
  assign bus.wr_uart    = w_wr;
  assign bus.w_data     = (r_state == ST_TX) ? r_res[DBIT*r_idx +: DBIT] : r_res[DBIT-1:0];
  assign bus.op_code    = r_op;
  assign bus.data_a     = r_a;
  assign bus.data_b     = r_b;
  assign bus.busy       = (r_state != ST_RX_OP);
  assign bus.frame_done = r_done;
  assign bus.frame_err  = r_err;

  // Inter-byte timeout counter: runs only while waiting for operand bytes.
  always_ff @(posedge clk) begin
    if (reset || !w_cnt_state || w_rd || w_tmo) begin
      r_cnt <= '0;
    end else if (TIMEOUT_CYC != 0) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Frame sequencing: receive into shadows, commit, latch result, transmit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RX_OP;
      r_idx   <= '0;
      r_op_sh <= '0;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_RX_OP: begin
          if (w_rd) begin
            r_op_sh <= bus.r_data[NB_OP-1:0];
            r_idx   <= '0;
            r_state <= ST_RX_A;
          end
        end
        ST_RX_A, ST_RX_B: begin
          if (w_rd) begin
            if (r_state == ST_RX_A) r_a_sh[DBIT*r_idx +: DBIT] <= bus.r_data;
            else                    r_b_sh[DBIT*r_idx +: DBIT] <= bus.r_data;
            if (w_last) begin
              r_idx   <= '0;
              r_state <= (r_state == ST_RX_A) ? ST_RX_B : ST_EXEC;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else if (w_tmo) begin
            r_state <= ST_RX_OP;
            r_idx   <= '0;
            r_op_sh <= '0;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_err   <= 1'b1;
          end
        end
        ST_EXEC: begin
          r_op    <= r_op_sh;
          r_a     <= r_a_sh;
          r_b     <= r_b_sh;
          r_state <= ST_LATCH;
        end
        ST_LATCH: begin
          r_res   <= bus.result;
          r_idx   <= '0;
          r_state <= ST_TX;
        end
        ST_TX: begin
          if (w_wr) begin
            if (w_last) begin
              r_idx   <= '0;
              r_state <= ST_RX_OP;
              r_done  <= 1'b1;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: r_state <= ST_RX_OP;
      endcase
    end
  end

endmodule
